// File: rtl/neosd_cmd_fsm.sv
// -----------------------------------------------------------------------------
// neosd_cmd_fsm
//
// SD command-line controller. Serialises one 48-bit SD command frame
// (start, transmission, index, argument, CRC7, end) onto CMD, optionally
// receives a 48-bit or 136-bit response and checks timeout, CRC7 and end
// bit. The gated SD clock is requested from neosd_clk for the whole
// transaction plus 8 trailing clocks. Every bit step happens on a qualified
// strobe (clkstrb_i while sd_clk_en_i is high).
//
// Ports:
//   clk_i, rstn_i          system clock, asynchronous active-low reset
//   clkstrb_i, sd_clk_en_i bit strobe and SD clock enable from neosd_clk
//   start_i                begin a transaction (honoured in IDLE only)
//   cmd_idx_i, cmd_arg_i   command index and argument
//   rsp_type_i             00 none, 01 R1/R6/R7, 10 R2, 11 R3 (no CRC)
//   sd_clk_req_o           SD clock request to neosd_clk
//   sd_cmd_o, sd_cmd_oe_o  CMD line value and output enable
//   sd_cmd_i               CMD line input (already synchronised)
//   busy_o, done_o         transaction in progress, one-cycle completion
//   err_timeout_o, err_crc_o, err_end_o  sticky response error flags
//   rsp_o                  received response bits (low 128 bits)
// -----------------------------------------------------------------------------
module neosd_cmd_fsm (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         clkstrb_i,
  input  logic         sd_clk_en_i,
  input  logic         start_i,
  input  logic [5:0]   cmd_idx_i,
  input  logic [31:0]  cmd_arg_i,
  input  logic [1:0]   rsp_type_i,
  output logic         sd_clk_req_o,
  output logic         sd_cmd_o,
  output logic         sd_cmd_oe_o,
  input  logic         sd_cmd_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         err_timeout_o,
  output logic         err_crc_o,
  output logic         err_end_o,
  output logic [127:0] rsp_o
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_TX       = 3'd1,
    S_WAIT_RSP = 3'd2,
    S_RX       = 3'd3,
    S_TRAIL    = 3'd4
  } state_t;

  // One serial CRC7 step, polynomial x^7 + x^3 + 1.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
    logic fb;
    fb = crc[6] ^ bit_in;
    return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  // CRC7 over the 40 header bits of a command frame, MSB first, seed 0.
  function automatic logic [6:0] crc7_calc40(input logic [39:0] data);
    logic [6:0] c;
    c = 7'h00;
    for (int i = 39; i >= 0; i--) begin
      c = crc7_step(c, data[i]);
    end
    return c;
  endfunction

  state_t         state_r, state_n;
  logic [46:0]    tx_sr_r, tx_sr_n;     // frame bits still to be sent after the current one
  logic [1:0]     type_r, type_n;
  logic [7:0]     cnt_r, cnt_n;         // QS counter, meaning depends on state
  logic [6:0]     crc_r, crc_n;
  logic [127:0]   rsp_r, rsp_n;
  logic           cmd_r, cmd_n;
  logic           oe_r, oe_n;
  logic           req_r, req_n;
  logic           busy_r, busy_n;
  logic           done_r, done_n;
  logic           err_to_r, err_to_n;
  logic           err_crc_r, err_crc_n;
  logic           err_end_r, err_end_n;

  logic           qs_s;
  logic [39:0]    hdr_s;
  logic [47:0]    frame_s;
  logic           is_r2_s;
  logic           rx_feed_s;
  logic           rx_last_s;
  logic           crc_chk_s;

  assign qs_s    = clkstrb_i & sd_clk_en_i;
  assign hdr_s   = {2'b01, cmd_idx_i, cmd_arg_i};
  assign frame_s = {hdr_s, crc7_calc40(hdr_s), 1'b1};

  // Response bit bookkeeping. cnt_r holds the number of bits already shifted
  // in after the start bit. The start bit itself is a 0 and leaves a zero CRC
  // seed unchanged, so seeding with 0 on entry to RX covers it.
  assign is_r2_s   = (type_r == 2'b10);
  assign rx_feed_s = is_r2_s ? ((cnt_r >= 8'd7) && (cnt_r <= 8'd126)) : (cnt_r <= 8'd38);
  assign rx_last_s = is_r2_s ? (cnt_r == 8'd134) : (cnt_r == 8'd46);
  assign crc_chk_s = (type_r != 2'b11);

  // State and datapath registers; every output is driven from these flops.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_r   <= S_IDLE;
      tx_sr_r   <= 47'd0;
      type_r    <= 2'b00;
      cnt_r     <= 8'd0;
      crc_r     <= 7'd0;
      rsp_r     <= 128'd0;
      cmd_r     <= 1'b1;
      oe_r      <= 1'b0;
      req_r     <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      err_to_r  <= 1'b0;
      err_crc_r <= 1'b0;
      err_end_r <= 1'b0;
    end else begin
      state_r   <= state_n;
      tx_sr_r   <= tx_sr_n;
      type_r    <= type_n;
      cnt_r     <= cnt_n;
      crc_r     <= crc_n;
      rsp_r     <= rsp_n;
      cmd_r     <= cmd_n;
      oe_r      <= oe_n;
      req_r     <= req_n;
      busy_r    <= busy_n;
      done_r    <= done_n;
      err_to_r  <= err_to_n;
      err_crc_r <= err_crc_n;
      err_end_r <= err_end_n;
    end
  end

  // Next-state and next-output logic for the command transaction.
  always_comb begin
    state_n   = state_r;
    tx_sr_n   = tx_sr_r;
    type_n    = type_r;
    cnt_n     = cnt_r;
    crc_n     = crc_r;
    rsp_n     = rsp_r;
    cmd_n     = cmd_r;
    oe_n      = oe_r;
    req_n     = req_r;
    busy_n    = busy_r;
    done_n    = 1'b0;
    err_to_n  = err_to_r;
    err_crc_n = err_crc_r;
    err_end_n = err_end_r;

    case (state_r)
      S_IDLE: begin
        if (start_i) begin
          tx_sr_n   = frame_s[46:0];
          type_n    = rsp_type_i;
          cnt_n     = 8'd0;
          rsp_n     = 128'd0;
          err_to_n  = 1'b0;
          err_crc_n = 1'b0;
          err_end_n = 1'b0;
          busy_n    = 1'b1;
          req_n     = 1'b1;
          oe_n      = 1'b1;
          cmd_n     = frame_s[47];
          state_n   = S_TX;
        end else begin
          state_n = S_IDLE;
        end
      end

      S_TX: begin
        if (qs_s) begin
          if (cnt_r == 8'd47) begin
            // 48th strobe: the end bit has been on the line for a full bit.
            oe_n  = 1'b0;
            cmd_n = 1'b1;
            cnt_n = 8'd0;
            crc_n = 7'd0;
            if (type_r == 2'b00) begin
              state_n = S_TRAIL;
            end else begin
              state_n = S_WAIT_RSP;
            end
          end else begin
            cmd_n   = tx_sr_r[46];
            tx_sr_n = {tx_sr_r[45:0], 1'b0};
            cnt_n   = cnt_r + 8'd1;
          end
        end else begin
          state_n = S_TX;
        end
      end

      S_WAIT_RSP: begin
        if (qs_s) begin
          if (!sd_cmd_i) begin
            cnt_n   = 8'd0;
            crc_n   = 7'd0;
            state_n = S_RX;
          end else if (cnt_r == 8'd63) begin
            err_to_n = 1'b1;
            cnt_n    = 8'd0;
            state_n  = S_TRAIL;
          end else begin
            cnt_n = cnt_r + 8'd1;
          end
        end else begin
          state_n = S_WAIT_RSP;
        end
      end

      S_RX: begin
        if (qs_s) begin
          rsp_n = {rsp_r[126:0], sd_cmd_i};
          if (rx_feed_s) begin
            crc_n = crc7_step(crc_r, sd_cmd_i);
          end else begin
            crc_n = crc_r;
          end
          if (rx_last_s) begin
            // rsp_r[6:0] already holds the seven received CRC bits here.
            err_end_n = ~sd_cmd_i;
            if (crc_chk_s) begin
              err_crc_n = (crc_r != rsp_r[6:0]);
            end else begin
              err_crc_n = 1'b0;
            end
            cnt_n   = 8'd0;
            state_n = S_TRAIL;
          end else begin
            cnt_n = cnt_r + 8'd1;
          end
        end else begin
          state_n = S_RX;
        end
      end

      S_TRAIL: begin
        // done_o is raised while still in TRAIL so a start_i coinciding
        // with the pulse is not taken.
        if (done_r) begin
          state_n = S_IDLE;
        end else if (qs_s) begin
          if (cnt_r == 8'd7) begin
            done_n = 1'b1;
            busy_n = 1'b0;
            req_n  = 1'b0;
            cnt_n  = 8'd0;
          end else begin
            cnt_n = cnt_r + 8'd1;
          end
        end else begin
          state_n = S_TRAIL;
        end
      end

      default: begin
        // Unreachable encoding: release the line and park in IDLE.
        state_n = S_IDLE;
        oe_n    = 1'b0;
        cmd_n   = 1'b1;
        req_n   = 1'b0;
        busy_n  = 1'b0;
        cnt_n   = 8'd0;
      end
    endcase
  end

  assign sd_clk_req_o  = req_r;
  assign sd_cmd_o      = cmd_r;
  assign sd_cmd_oe_o   = oe_r;
  assign busy_o        = busy_r;
  assign done_o        = done_r;
  assign err_timeout_o = err_to_r;
  assign err_crc_o     = err_crc_r;
  assign err_end_o     = err_end_r;
  assign rsp_o         = rsp_r;

endmodule

// File: tb/tb_neosd_cmd_fsm.sv
// -----------------------------------------------------------------------------
// tb_neosd_cmd_fsm
//
// Self-checking bench for neosd_cmd_fsm. A transaction-level model tracks
// the number of qualified strobes since acceptance and derives every output
// from that count with plain arithmetic; the card side of the CMD line is
// played from the same count. Directed cases pin known SD frames, then a
// randomized loop covers response types, delays, CRC and end-bit faults.
// -----------------------------------------------------------------------------
module tb_neosd_cmd_fsm;

  logic         clk_i = 1'b0;
  logic         rstn_i;
  logic         clkstrb_i;
  logic         sd_clk_en_i;
  logic         start_i;
  logic [5:0]   cmd_idx_i;
  logic [31:0]  cmd_arg_i;
  logic [1:0]   rsp_type_i;
  logic         sd_clk_req_o;
  logic         sd_cmd_o;
  logic         sd_cmd_oe_o;
  logic         sd_cmd_i;
  logic         busy_o;
  logic         done_o;
  logic         err_timeout_o;
  logic         err_crc_o;
  logic         err_end_o;
  logic [127:0] rsp_o;

  neosd_cmd_fsm dut (
    .clk_i         (clk_i),
    .rstn_i        (rstn_i),
    .clkstrb_i     (clkstrb_i),
    .sd_clk_en_i   (sd_clk_en_i),
    .start_i       (start_i),
    .cmd_idx_i     (cmd_idx_i),
    .cmd_arg_i     (cmd_arg_i),
    .rsp_type_i    (rsp_type_i),
    .sd_clk_req_o  (sd_clk_req_o),
    .sd_cmd_o      (sd_cmd_o),
    .sd_cmd_oe_o   (sd_cmd_oe_o),
    .sd_cmd_i      (sd_cmd_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .err_timeout_o (err_timeout_o),
    .err_crc_o     (err_crc_o),
    .err_end_o     (err_end_o),
    .rsp_o         (rsp_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: transaction parameters and strobe count since acceptance.
  bit           m_act;
  int           m_q, m_qend, m_d, m_len;
  logic [1:0]   m_type;
  logic [47:0]  m_frame;
  logic [135:0] m_resp;
  int           nx_d;
  logic [135:0] nx_resp;

  // Expected outputs.
  logic         e_req, e_cmd, e_oe, e_busy, e_done, e_to, e_crc, e_end;
  logic [127:0] e_rsp;

  logic [47:0]  tx_cap;
  int           done_cnt = 0;
  int           stb_mode = 0;
  bit           noise    = 1'b0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk128(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // CRC7 by polynomial long division of msg[nbits-1:0] * x^7 by x^7+x^3+1.
  function automatic logic [6:0] crc_div(input logic [127:0] msg, input int nbits);
    logic [134:0] w;
    w = {msg, 7'b0};
    for (int i = nbits + 6; i >= 7; i--) begin
      if (w[i]) w[i -: 8] = w[i -: 8] ^ 8'h89;
    end
    return w[6:0];
  endfunction

  function automatic logic [6:0] resp_crc();
    logic [127:0] msg;
    msg = '0;
    if (m_len == 47) begin
      msg[39:0] = m_resp[47:8];
      return crc_div(msg, 40);
    end else begin
      msg[119:0] = m_resp[127:8];
      return crc_div(msg, 120);
    end
  endfunction

  // Value the card drives for wait/response sample i (0-based).
  function automatic logic line_bit(input int i);
    if (i < m_d) return 1'b1;
    else if (i <= m_d + m_len) return m_resp[m_len - (i - m_d)];
    else return 1'b1;
  endfunction

  task automatic model_eval();
    int rs, m;
    logic [135:0] v;
    e_oe   = (m_q < 48);
    e_cmd  = (m_q < 48) ? m_frame[47 - m_q] : 1'b1;
    e_busy = (m_q < m_qend);
    e_req  = e_busy;
    e_done = (m_q == m_qend);
    e_to   = (m_type != 2'b00) && (m_d >= 64) && (m_q >= 48 + 64);
    e_rsp  = '0;
    e_crc  = 1'b0;
    e_end  = 1'b0;
    if (m_type != 2'b00 && m_d < 64) begin
      rs = 49 + m_d;
      m  = m_q - rs;
      if (m < 0) m = 0;
      if (m > m_len) m = m_len;
      v = m_resp << (136 - m_len);
      v = v >> (136 - m_len);
      v = v >> (m_len - m);
      e_rsp = v[127:0];
      if (m_q >= rs + m_len) begin
        e_end = ~m_resp[0];
        e_crc = (m_type != 2'b11) && (resp_crc() != m_resp[7:1]);
      end
    end
  endtask

  task automatic model_posedge();
    logic [127:0] hdr;
    if (m_act) begin
      if (m_q == m_qend) m_act = 1'b0;
      else if (clkstrb_i && sd_clk_en_i) m_q++;
    end else if (start_i && rstn_i) begin
      m_act   = 1'b1;
      m_q     = 0;
      m_type  = rsp_type_i;
      m_len   = (rsp_type_i == 2'b10) ? 135 : 47;
      m_d     = nx_d;
      m_resp  = nx_resp;
      hdr     = '0;
      hdr[39:0] = {2'b01, cmd_idx_i, cmd_arg_i};
      m_frame = {hdr[39:0], crc_div(hdr, 40), 1'b1};
      if (m_type == 2'b00) m_qend = 56;
      else if (m_d >= 64) m_qend = 48 + 64 + 8;
      else m_qend = 49 + m_d + m_len + 8;
      tx_cap  = '0;
    end
    if (m_act) model_eval();
    else begin
      e_done = 1'b0; e_busy = 1'b0; e_req = 1'b0; e_oe = 1'b0; e_cmd = 1'b1;
    end
  endtask

  task automatic compare();
    chk1("busy", busy_o, e_busy);
    chk1("clk_req", sd_clk_req_o, e_req);
    chk1("cmd_oe", sd_cmd_oe_o, e_oe);
    chk1("cmd", sd_cmd_o, e_cmd);
    chk1("done", done_o, e_done);
    chk1("err_timeout", err_timeout_o, e_to);
    chk1("err_crc", err_crc_o, e_crc);
    chk1("err_end", err_end_o, e_end);
    chk128("rsp", rsp_o, e_rsp);
    if (m_act && m_q < 48) tx_cap[47 - m_q] = sd_cmd_o;
    if (done_o) done_cnt++;
  endtask

  task automatic drive();
    start_i = 1'b0;
    if (stb_mode == 1) begin
      clkstrb_i   = ~clkstrb_i;
      sd_clk_en_i = 1'b0;
    end else begin
      clkstrb_i   = 1'($urandom_range(0, 1));
      sd_clk_en_i = ($urandom_range(0, 9) != 0);
    end
    sd_cmd_i = (m_act && m_type != 2'b00 && m_q >= 48) ? line_bit(m_q - 48) : 1'b1;
    if (noise && m_act) begin
      start_i    = ($urandom_range(0, 7) == 0);
      cmd_idx_i  = 6'($urandom_range(0, 63));
      cmd_arg_i  = $urandom;
      rsp_type_i = 2'($urandom_range(0, 3));
    end
    // Raise start during the done pulse: it must be ignored.
    if (m_act && m_q == m_qend) start_i = 1'b1;
  endtask

  task automatic step();
    @(posedge clk_i);
    model_posedge();
    @(negedge clk_i);
    compare();
    drive();
  endtask

  task automatic run_txn(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] typ,
                         input int d, input logic [135:0] resp);
    int cyc;
    cmd_idx_i  = idx;
    cmd_arg_i  = arg;
    rsp_type_i = typ;
    nx_d       = d;
    nx_resp    = resp;
    start_i    = 1'b1;
    noise      = 1'b0;
    step();
    noise = 1'b1;
    cyc   = 0;
    while (m_act && cyc < 4000) begin
      step();
      cyc++;
    end
    noise = 1'b0;
    n_checks++;
    if (m_act) begin
      n_fail++;
      $display("FAIL txn_budget: still active after %0d cycles, required idle", cyc);
      m_act = 1'b0;
    end
  endtask

  function automatic logic [135:0] mk48(input logic [5:0] idx, input logic [31:0] pay,
                                        input bit bad, input logic endb);
    logic [127:0] h;
    logic [6:0]   c;
    logic [135:0] r;
    h = '0;
    h[39:0] = {2'b00, idx, pay};
    c = crc_div(h, 40) ^ (bad ? 7'h01 : 7'h00);
    r = '0;
    r[47:0] = {h[39:0], c, endb};
    return r;
  endfunction

  function automatic logic [135:0] mk136(input logic [127:0] rnd, input bit bad, input logic endb);
    logic [127:0] h;
    logic [6:0]   c;
    h = {2'b00, 6'h3F, rnd[119:0]};
    c = crc_div({8'h00, rnd[119:0]}, 120) ^ (bad ? 7'h40 : 7'h00);
    return {h, c, endb};
  endfunction

  initial begin
    logic [135:0] r;
    logic [127:0] rnd;
    int           dc, d, sel, cyc;
    logic [1:0]   typ;

    rstn_i      = 1'b0;
    clkstrb_i   = 1'b0;
    sd_clk_en_i = 1'b1;
    start_i     = 1'b0;
    cmd_idx_i   = 6'd0;
    cmd_arg_i   = 32'd0;
    rsp_type_i  = 2'b00;
    sd_cmd_i    = 1'b1;
    m_act = 1'b0; m_q = 0; m_qend = 0; m_d = 0; m_len = 47; m_type = 2'b00;
    m_frame = '0; m_resp = '0; nx_d = 0; nx_resp = '0; tx_cap = '0;
    e_req = 1'b0; e_cmd = 1'b1; e_oe = 1'b0; e_busy = 1'b0; e_done = 1'b0;
    e_to = 1'b0; e_crc = 1'b0; e_end = 1'b0; e_rsp = '0;

    // Reset values.
    @(negedge clk_i);
    compare();
    @(negedge clk_i);
    rstn_i = 1'b1;
    for (int i = 0; i < 3; i++) step();

    // Pin the model's CRC against well-known SD frames.
    chk128("pin crc CMD0", 128'(crc_div(128'h40_0000_0000, 40)), 128'h4A);
    chk128("pin crc CMD8", 128'(crc_div(128'h48_0000_01AA, 40)), 128'h43);
    chk128("pin crc R7", 128'(crc_div(128'h08_0000_01AA, 40)), 128'h09);

    // CMD0, no response.
    dc = done_cnt;
    run_txn(6'd0, 32'd0, 2'b00, 0, '0);
    chk128("cmd0 frame", 128'(tx_cap), 128'h4000_0000_0095);
    chk128("cmd0 done pulses", 128'(done_cnt - dc), 128'd1);
    chk128("cmd0 errors", 128'({err_timeout_o, err_crc_o, err_end_o}), 128'd0);

    // CMD8 with a valid R7.
    r = '0; r[47:0] = 48'h0800_0001_AA13;
    dc = done_cnt;
    run_txn(6'd8, 32'h1AA, 2'b01, 4, r);
    chk128("cmd8 frame", 128'(tx_cap), 128'h4800_0001_AA87);
    chk128("cmd8 rsp", rsp_o, 128'h0800_0001_AA13);
    chk128("cmd8 errors", 128'({err_timeout_o, err_crc_o, err_end_o}), 128'd0);
    chk128("cmd8 done pulses", 128'(done_cnt - dc), 128'd1);

    // Same, corrupted CRC byte.
    r = '0; r[47:0] = 48'h0800_0001_AA15;
    dc = done_cnt;
    run_txn(6'd8, 32'h1AA, 2'b01, 4, r);
    chk1("cmd8 bad crc flag", err_crc_o, 1'b1);
    chk1("cmd8 bad crc end ok", err_end_o, 1'b0);
    chk128("cmd8 bad crc done", 128'(done_cnt - dc), 128'd1);

    // No response at all: timeout.
    run_txn(6'd55, 32'd0, 2'b01, 1000, '0);
    chk1("timeout flag", err_timeout_o, 1'b1);
    chk128("timeout rsp", rsp_o, 128'd0);

    // Start bit on the 64th sample is still in time.
    r = mk48(6'd3, 32'h1234_5678, 1'b0, 1'b1);
    run_txn(6'd3, 32'd0, 2'b01, 63, r);
    chk1("late start no timeout", err_timeout_o, 1'b0);
    chk128("late start rsp", rsp_o, r[127:0]);

    // R2 responses.
    rnd = {$urandom, $urandom, $urandom, $urandom};
    r = mk136(rnd, 1'b0, 1'b1);
    run_txn(6'd2, 32'd0, 2'b10, 3, r);
    chk128("r2 rsp", rsp_o, r[127:0]);
    chk128("r2 errors", 128'({err_timeout_o, err_crc_o, err_end_o}), 128'd0);
    r = mk136(rnd, 1'b0, 1'b0);
    run_txn(6'd9, 32'h5555_0000, 2'b10, 7, r);
    chk1("r2 end flag", err_end_o, 1'b1);
    chk1("r2 end crc ok", err_crc_o, 1'b0);

    // Stall mid-TX, then reset during RX.
    cmd_idx_i  = 6'd17;
    cmd_arg_i  = 32'hCAFE_F00D;
    rsp_type_i = 2'b01;
    nx_d       = 2;
    nx_resp    = mk48(6'd17, 32'h0BAD_BEEF, 1'b0, 1'b1);
    start_i    = 1'b1;
    step();
    cyc = 0;
    while (m_q < 20 && cyc < 1000) begin step(); cyc++; end
    stb_mode = 1;
    for (int i = 0; i < 20; i++) step();
    stb_mode = 0;
    while (m_q < 61 && cyc < 2000) begin step(); cyc++; end
    chk1("in rx before reset", (m_q >= 61) ? busy_o : 1'b0, 1'b1);
    rstn_i = 1'b0;
    m_act = 1'b0;
    e_req = 1'b0; e_cmd = 1'b1; e_oe = 1'b0; e_busy = 1'b0; e_done = 1'b0;
    e_to = 1'b0; e_crc = 1'b0; e_end = 1'b0; e_rsp = '0;
    #1;
    compare();
    @(negedge clk_i);
    compare();
    rstn_i = 1'b1;
    for (int i = 0; i < 3; i++) step();

    // Randomized transactions.
    for (int t = 0; t < 24; t++) begin
      typ = 2'($urandom_range(0, 3));
      sel = $urandom_range(0, 9);
      if (sel < 6) d = $urandom_range(0, 8);
      else if (sel < 8) d = $urandom_range(60, 66);
      else d = 300;
      if (typ == 2'b10) begin
        rnd = {$urandom, $urandom, $urandom, $urandom};
        r = mk136(rnd, $urandom_range(0, 3) == 0, $urandom_range(0, 5) != 0);
      end else begin
        r = mk48(6'($urandom_range(0, 63)), $urandom, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 5) != 0);
      end
      run_txn(6'($urandom_range(0, 63)), $urandom, typ, d, r);
      for (int i = 0; i < 2; i++) step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/neosd_cmd_fsm.md
# neosd_cmd_fsm

SD command-line controller for the neosd host. Serialises one 48-bit SD command (start, transmission, index, argument, CRC7, end bit) onto CMD and optionally receives a 48-bit or 136-bit response, checking the timeout, CRC7 and end bit. It requests the gated SD clock from `neosd_clk` for the duration of the transaction plus 8 trailing clocks. All bit timing is derived from `neosd_clk`'s `clkstrb_o`/`sd_clk_en_o`.

## Interface
- No parameters.
- `clk_i` in 1: system clock.
- `rstn_i` in 1: reset, asynchronous, active-low.
- `clkstrb_i` in 1: bit strobe from `neosd_clk.clkstrb_o`.
- `sd_clk_en_i` in 1: from `neosd_clk.sd_clk_en_o`; a strobe counts only when this is high (a qualified strobe, QS).
- `start_i` in 1: begin a transaction; accepted only in IDLE.
- `cmd_idx_i` in 6: command index.
- `cmd_arg_i` in 32: command argument.
- `rsp_type_i` in 2: 00 none, 01 48-bit with CRC (R1/R6/R7), 10 136-bit (R2), 11 48-bit without CRC (R3).
- `sd_clk_req_o` out 1: clock request to one bit of `neosd_clk.sd_clk_req_i`.
- `sd_cmd_o` out 1: CMD output value.
- `sd_cmd_oe_o` out 1: CMD output enable.
- `sd_cmd_i` in 1: CMD input (synchronised externally).
- `busy_o` out 1: transaction in progress.
- `done_o` out 1: one-cycle completion pulse.
- `err_timeout_o`, `err_crc_o`, `err_end_o` out 1 each: sticky error flags.
- `rsp_o` out 128: received response bits.

## Operation
- States: IDLE, TX, WAIT_RSP, RX, TRAIL.
- IDLE: `start_i`=1 latches the index, argument and type. It clears `rsp_o` and all error flags, sets `busy_o`=1 and `sd_clk_req_o`=1, and enters TX. `start_i` outside IDLE is ignored.
- TX: 48-bit frame, MSB first:
  - bit 47 = 0; bit 46 = 1; bits 45:40 = index; bits 39:8 = argument; bits 7:1 = CRC7; bit 0 = 1.
  - CRC7 uses polynomial x^7+x^3+1, initial value 0, and is computed serially over bits 47:8.
  - `sd_cmd_oe_o`=1 and `sd_cmd_o`=bit 47 from the cycle after acceptance.
  - Each QS advances to the next bit. The 48th QS releases the line (`oe`=0, `sd_cmd_o`=1).
  - Next state: WAIT_RSP, or TRAIL if the type is 00.
- WAIT_RSP: samples `sd_cmd_i` at each QS.
  - Sample 0 = start bit: enter RX.
  - 64 QS without a start bit: set `err_timeout_o` and enter TRAIL.
- RX: shifts each QS sample into the LSB of an internal shift register (47 bits for 48-bit responses, 135 bits for R2).
  - `rsp_o` = low 128 bits of the shift register, zero-extended. For 48-bit responses, `rsp_o[46]`=transmission bit, `[45:40]`=index, `[39:8]`=payload, `[7:1]`=CRC, `[0]`=end bit.
  - CRC7 is computed over frame bits 47:8 for type 01 (start bit included as 0) and over 127:8 for type 10. Type 11 skips the CRC check.
  - After the last bit: `err_end_o`=1 if the end bit is 0; `err_crc_o`=1 if the checked CRC mismatches. Then enter TRAIL.
- TRAIL: 8 QS with the line released, then `done_o`=1 for one cycle, `busy_o`=0, `sd_clk_req_o`=0, and return to IDLE.
- Errors and `rsp_o` hold until the next accepted start.

## Timing
- Reset values: `sd_clk_req_o`=0, `sd_cmd_o`=1, `sd_cmd_oe_o`=0, `busy_o`=0, `done_o`=0, all errors 0, `rsp_o`=0, state IDLE.
- All outputs are registered. Bit changes take effect the `clk_i` cycle after the QS.
- A strobe with `sd_clk_en_i`=0 (clock stalled by the data FSM) does not advance any counter or shift.
- Minimum latency, type 00: 48 + 8 QS after acceptance, plus 1 cycle to `done_o`.
- Asynchronous reset mid-transaction returns immediately to reset values. The line is released and the clock request is dropped.
- `start_i` in the same cycle as `done_o` is ignored, because the FSM is not yet in IDLE.

## Test plan
- CMD0, arg 0, type 00 -> CMD shows 0x400000000095 MSB first over 48 QS, then 8 trailing QS; `done_o` pulses; no errors.
- CMD8, arg 0x1AA, type 01; card replies 0x080000 01AA13 after 5 QS -> TX frame 0x48000001AA87; `rsp_o`=0x0800_0001_AA13; no errors.
- Same as the previous test, but the response CRC byte is 0x15 -> `err_crc_o`=1, `done_o` still pulses.
- Type 01, CMD held high -> `err_timeout_o`=1 after exactly 64 QS in WAIT_RSP, then 8 trailing QS and `done_o`.
- Type 10 with a 136-bit response whose CRC is generated by the bench model -> `rsp_o` equals frame bits 127:0; no errors. Repeat with end bit 0 -> `err_end_o`=1.
- `sd_clk_en_i` low for 10 strobes in mid-TX, then `rstn_i` pulsed during RX -> no bit advance while low; after reset, all outputs are at reset values.
